// File: rtl/bcd_counter_scan_disp.sv
// Multi-decade BCD up/down counter with load, terminal-count output and a scanned active-low
// 7-segment driver. Define LEADING_ZERO_BLANK_EN to blank leading-zero digits above digit 0.
module bcd_counter_scan_disp #(
    parameter int unsigned DIGITS  = 4,
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned TICK_HZ = 1,
    parameter int unsigned SCAN_HZ = 1000
) (
    input  logic                  CLK_50,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  load_n,
    input  logic                  up_dn,
    input  logic [4*DIGITS-1:0]   load_data,
    output logic [4*DIGITS-1:0]   count,
    output logic                  cout,
    output logic [DIGITS-1:0]     SEL,
    output logic [7:0]            DIG
);
    localparam int unsigned CW       = 4 * DIGITS;
    localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int unsigned TW       = $clog2(TICK_DIV);
    localparam int unsigned SW       = $clog2(SCAN_DIV);
    localparam int unsigned IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIGITS-1:0] SEL_RST = ~DIGITS'(1);

    logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
    logic [SW-1:0]     scan_cnt_q, scan_cnt_d;
    logic [IW-1:0]     scan_idx_q, scan_idx_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DIGITS-1:0] sel_q, sel_d;
    logic [7:0]        dig_q, dig_d;
    logic              tick_c, scan_c;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // Rate dividers: single-cycle strobes, no derived clocks.
    always_comb begin : divider_next
        tick_c     = (tick_cnt_q == TW'(TICK_DIV - 1));
        scan_c     = (scan_cnt_q == SW'(SCAN_DIV - 1));
        tick_cnt_d = tick_c ? '0 : tick_cnt_q + 1'b1;
        scan_cnt_d = scan_c ? '0 : scan_cnt_q + 1'b1;
    end

    // Load (clamped) has priority over counting; the ripple flag is carry or borrow.
    always_comb begin : count_next
        logic [3:0] nib;
        logic       ripple;
        count_d = count_q;
        nib     = '0;
        ripple  = 1'b1;
        if (tick_c && en) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                if (!load_n) begin
                    nib = load_data[4*i +: 4];
                    if (nib > 4'd9) nib = 4'd9;
                end else begin
                    nib = count_q[4*i +: 4];
                    if (ripple) begin
                        if (up_dn) begin
                            ripple = (nib >= 4'd9);
                            nib    = ripple ? 4'd0 : nib + 4'd1;
                        end else begin
                            ripple = (nib == 4'd0);
                            nib    = ripple ? 4'd9 : nib - 4'd1;
                        end
                    end
                end
                count_d[4*i +: 4] = nib;
            end
        end
    end

    always_comb begin : terminal_count
        logic all9, all0;
        all9 = 1'b1;
        all0 = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            all9 = all9 & (count_q[4*i +: 4] == 4'd9);
            all0 = all0 & (count_q[4*i +: 4] == 4'd0);
        end
        cout = up_dn ? all9 : all0;
    end

    // Latch the current index's digit into SEL/DIG together, then advance the index.
    always_comb begin : scan_next
        logic [3:0] cur;
        logic       zero_above;
        logic       blank;
        logic [6:0] seg;
        cur        = '0;
        zero_above = 1'b1;
        blank      = 1'b0;
        scan_idx_d = scan_idx_q;
        sel_d      = sel_q;
        dig_d      = dig_q;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            zero_above = zero_above & (count_q[4*i +: 4] == 4'd0);
            if (IW'(i) == scan_idx_q) begin
                cur   = count_q[4*i +: 4];
                blank = zero_above && (i != 0);
            end
        end
        seg = seg7(cur);
`ifdef LEADING_ZERO_BLANK_EN
        if (blank) seg = 7'h7F;
`endif
        if (scan_c) begin
            sel_d      = ~(DIGITS'(1) << scan_idx_q);
            dig_d      = {~cout, seg};
            scan_idx_d = (scan_idx_q == IW'(DIGITS - 1)) ? '0 : scan_idx_q + 1'b1;
        end
    end

    always_ff @(posedge CLK_50 or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
            scan_cnt_q <= '0;
            scan_idx_q <= '0;
            count_q    <= '0;
            sel_q      <= SEL_RST;
            dig_q      <= 8'hFF;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            scan_cnt_q <= scan_cnt_d;
            scan_idx_q <= scan_idx_d;
            count_q    <= count_d;
            sel_q      <= sel_d;
            dig_q      <= dig_d;
        end
    end

    assign count = count_q;
    assign SEL   = sel_q;
    assign DIG   = dig_q;

endmodule

// File: tb/tb_bcd_counter_scan_disp.sv
// Directed bench for bcd_counter_scan_disp (3 digits, tick every 10 cycles, scan every 2).
module tb_bcd_counter_scan_disp;
    logic        clk = 1'b0;
    logic        rst_n, en, load_n, up_dn;
    logic [11:0] load_data, count;
    logic        cout;
    logic [2:0]  sel;
    logic [7:0]  dig;
    int          errors = 0;
    int          checks = 0;
    int          edges;

    typedef struct {
        logic        en;
        logic        load_n;
        logic        up_dn;
        logic [11:0] data;
        logic [11:0] exp_count;
        logic        exp_cout;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;

    bcd_counter_scan_disp #(
        .DIGITS(3), .CLK_HZ(100), .TICK_HZ(10), .SCAN_HZ(50)
    ) dut (
        .CLK_50(clk), .rst_n(rst_n), .en(en), .load_n(load_n), .up_dn(up_dn),
        .load_data(load_data), .count(count), .cout(cout), .SEL(sel), .DIG(dig)
    );

    function automatic vec_t mk(input logic e, input logic l, input logic u,
                                input logic [11:0] d, input logic [11:0] ec, input logic eo);
        vec_t v;
        v.en = e; v.load_n = l; v.up_dn = u; v.data = d; v.exp_count = ec; v.exp_cout = eo;
        return v;
    endfunction

    function automatic logic [6:0] seg_exp(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [3:0] digit_of(input logic [11:0] v, input int d);
        logic [11:0] t;
        t = v >> (4 * d);
        return t[3:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_tick();
        repeat (10) @(posedge clk);
        #1;
    endtask

    // Checks both cycles of the scan period that started at the last even edge.
    task automatic check_scan(input string name, input logic [11:0] val, input logic dp_n);
        int          d;
        logic [2:0]  one;
        logic [2:0]  exp_sel;
        logic [7:0]  exp_dig;
        one     = 3'b001;
        d       = (edges / 2 - 1) % 3;
        exp_sel = ~(one << d);
        exp_dig = {dp_n, seg_exp(digit_of(val, d))};
`ifdef LEADING_ZERO_BLANK_EN
        if (d > 0 && digit_of(val, d) == 4'd0 && (d == 2 || digit_of(val, 2) == 4'd0))
            exp_dig[6:0] = 7'h7F;
`endif
        check({name, "_sel"}, 32'(sel), 32'(exp_sel));
        check({name, "_dig"}, 32'(dig), 32'(exp_dig));
        @(posedge clk); #1;
        check({name, "_sel_hold"}, 32'(sel), 32'(exp_sel));
        check({name, "_dig_hold"}, 32'(dig), 32'(exp_dig));
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 1; i <= 12; i++)
            vecs.push_back(mk(1, 1, 1, 12'h000, {4'h0, 4'(i / 10), 4'(i % 10)}, 0));
        vecs.push_back(mk(1, 0, 1, 12'h998, 12'h998, 0));
        vecs.push_back(mk(1, 1, 1, 12'h000, 12'h999, 1));
        vecs.push_back(mk(1, 1, 1, 12'h000, 12'h000, 0));
        vecs.push_back(mk(1, 1, 0, 12'h000, 12'h999, 0));
        vecs.push_back(mk(1, 0, 0, 12'h100, 12'h100, 0));
        vecs.push_back(mk(1, 1, 0, 12'h000, 12'h099, 0));
        vecs.push_back(mk(1, 1, 0, 12'h000, 12'h098, 0));
        vecs.push_back(mk(1, 1, 1, 12'h000, 12'h099, 0));
        vecs.push_back(mk(1, 1, 1, 12'h000, 12'h100, 0));
        vecs.push_back(mk(1, 0, 0, 12'hF3A, 12'h939, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 0, 0, 12'h000, 12'h939, 0));
        vecs.push_back(mk(1, 0, 0, 12'h001, 12'h001, 0));
        vecs.push_back(mk(1, 1, 0, 12'h000, 12'h000, 1));

        rst_n = 1'b0; en = 1'b0; load_n = 1'b1; up_dn = 1'b1; load_data = '0;
        #12;
        check("rst_count", 32'(count), 32'h000);
        check("rst_sel",   32'(sel),   32'b110);
        check("rst_dig",   32'(dig),   32'hFF);
        check("rst_cout",  32'(cout),  32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("dig_blank_pre_scan", 32'(dig), 32'hFF);
        repeat (9) @(posedge clk); #1;
        check("hold_en0_first_tick", 32'(count), 32'h000);

        foreach (vecs[i]) begin
            en = vecs[i].en; load_n = vecs[i].load_n; up_dn = vecs[i].up_dn;
            load_data = vecs[i].data;
            wait_tick();
            check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
            check($sformatf("vec%0d_cout", i),  32'(cout),  32'(vecs[i].exp_cout));
        end

        // cout follows up_dn without a tick
        en = 1'b0; load_n = 1'b1;
        up_dn = 1'b1; #1;
        check("cout_comb_up", 32'(cout), 32'h0);
        up_dn = 1'b0; #1;
        check("cout_comb_dn", 32'(cout), 32'h1);
        repeat (2) @(posedge clk); #1;
        check("dp_n_on_cout", 32'(dig[7]), 32'h0);
        repeat (8) @(posedge clk); #1;
        check("hold_after_dp", 32'(count), 32'h000);

        // Scan 123 across six periods
        en = 1'b1; load_n = 1'b0; up_dn = 1'b1; load_data = 12'h123;
        wait_tick();
        check("load_123", 32'(count), 32'h123);
        en = 1'b0; load_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        for (int p = 0; p < 6; p++) check_scan($sformatf("scan123_p%0d", p), 12'h123, 1'b1);
        repeat (6) @(posedge clk); #1;

        // Asynchronous reset mid tick period
        en = 1'b1; load_n = 1'b0; load_data = 12'h456;
        wait_tick();
        check("load_456", 32'(count), 32'h456);
        load_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        #1;
        check("midrst_count", 32'(count), 32'h000);
        check("midrst_sel",   32'(sel),   32'b110);
        check("midrst_dig",   32'(dig),   32'hFF);
        @(negedge clk); rst_n = 1'b1;
        repeat (9) @(posedge clk); #1;
        check("no_early_tick", 32'(count), 32'h000);
        @(posedge clk); #1;
        check("first_tick_after_rst", 32'(count), 32'h001);

        // Leading-zero display of 007
        load_n = 1'b0; load_data = 12'h007;
        wait_tick();
        check("load_007", 32'(count), 32'h007);
        en = 1'b0; load_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        for (int p = 0; p < 3; p++) check_scan($sformatf("scan007_p%0d", p), 12'h007, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
